// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package mult_div_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int CNT_W_DEF = $clog2(WIDTH_DEF);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_e;

   typedef enum logic {
      OP_MULT = 1'b0,
      OP_DIV  = 1'b1
   } op_e;

   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/mult_div_seq_div_step.sv
// Combinational restoring-division step: one quotient bit per call.
module div_step
   import mult_div_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH:0]   partial,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic             q_bit
);

   logic [WIDTH:0] divisor_ext_s;
   logic [WIDTH:0] diff_s;

   // Trial subtraction; keep the difference only when it does not go negative.
   always_comb begin
      divisor_ext_s = {1'b0, divisor};
      diff_s        = partial - divisor_ext_s;
      if (partial >= divisor_ext_s) begin
         q_bit    = 1'b1;
         rem_next = diff_s[WIDTH-1:0];
      end else begin
         q_bit    = 1'b0;
         rem_next = partial[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/mult_div_seq.sv
// Iterative signed MULT/DIV sequencer with HI/LO result registers.
// Optional feature: MULTDIV_DIVZERO_TRAP_EN short-circuits divide-by-zero to DONE.
module mult_div_seq
   import mult_div_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [WIDTH-1:0]   ZERO_W  = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0]   ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [2*WIDTH-1:0] ONE_2W  = {{(2*WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0]   CNT_Z   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e             state_r, state_s;
   op_e                op_r;
   logic               sign_a_r, sign_b_r;
   logic [WIDTH-1:0]   mag_a_r, mag_b_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [2*WIDTH-1:0] acc_r;
   logic               busy_r, done_r, div_zero_r;
   logic [WIDTH-1:0]   hi_r, lo_r;

   logic [WIDTH-1:0]   mag_in_a_s, mag_in_b_s;
   logic [2*WIDTH-1:0] load_acc_s, calc_acc_s, prod_s;
   logic [WIDTH:0]     mul_sum_s, partial_s;
   logic [WIDTH-1:0]   rem_s, quo_s, hi_fix_s, lo_fix_s;
   logic               q_bit_s, trap_s;

   div_step #(.WIDTH(WIDTH)) u_div_step (
      .partial  (partial_s),
      .divisor  (mag_b_r),
      .rem_next (rem_s),
      .q_bit    (q_bit_s)
   );

   // Operand magnitudes, one iteration of the shift-add / restoring datapath, and sign fix-up.
   always_comb begin
      mag_in_a_s = a[WIDTH-1] ? (~a + ONE_W) : a;
      mag_in_b_s = b[WIDTH-1] ? (~b + ONE_W) : b;
`ifdef MULTDIV_DIVZERO_TRAP_EN
      trap_s = (op_e'(op) == OP_DIV) && (b == ZERO_W);
`else
      trap_s = 1'b0;
`endif
      // MULT keeps the multiplier in the low half; DIV keeps the dividend there.
      if (op_e'(op) == OP_MULT) begin
         load_acc_s = {ZERO_W, mag_in_b_s};
      end else begin
         load_acc_s = {ZERO_W, mag_in_a_s};
      end

      mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, mag_a_r} : {(WIDTH+1){1'b0}});
      partial_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
      if (op_r == OP_MULT) begin
         calc_acc_s = {mul_sum_s, acc_r[WIDTH-1:1]};
      end else begin
         calc_acc_s = {rem_s, acc_r[WIDTH-2:0], q_bit_s};
      end

      prod_s = (sign_a_r ^ sign_b_r) ? (~acc_r + ONE_2W) : acc_r;
      rem_s_fix_block: begin
         quo_s = acc_r[WIDTH-1:0];
      end
      if (op_r == OP_MULT) begin
         hi_fix_s = prod_s[2*WIDTH-1:WIDTH];
         lo_fix_s = prod_s[WIDTH-1:0];
      end else begin
         hi_fix_s = sign_a_r ? (~acc_r[2*WIDTH-1:WIDTH] + ONE_W) : acc_r[2*WIDTH-1:WIDTH];
         lo_fix_s = (sign_a_r ^ sign_b_r) ? (~quo_s + ONE_W) : quo_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s = trap_s ? DONE : CALC;
            end else begin
               state_s = IDLE;
            end
         end
         CALC: begin
            if (cnt_r == CNT_Z) begin
               state_s = FIX;
            end else begin
               state_s = CALC;
            end
         end
         FIX:     state_s = DONE;
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= IDLE;
         op_r       <= OP_MULT;
         sign_a_r   <= 1'b0;
         sign_b_r   <= 1'b0;
         mag_a_r    <= ZERO_W;
         mag_b_r    <= ZERO_W;
         cnt_r      <= CNT_Z;
         acc_r      <= {(2*WIDTH){1'b0}};
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         div_zero_r <= 1'b0;
         hi_r       <= ZERO_W;
         lo_r       <= ZERO_W;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s != IDLE);
         done_r  <= (state_s == DONE);
         case (state_r)
            IDLE: begin
               if (start) begin
                  op_r       <= op_e'(op);
                  sign_a_r   <= a[WIDTH-1];
                  sign_b_r   <= b[WIDTH-1];
                  mag_a_r    <= mag_in_a_s;
                  mag_b_r    <= mag_in_b_s;
                  cnt_r      <= CNT_MAX;
                  acc_r      <= load_acc_s;
                  div_zero_r <= trap_s;
               end
            end
            CALC: begin
               acc_r <= calc_acc_s;
               if (cnt_r != CNT_Z) begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            FIX: begin
               hi_r <= hi_fix_s;
               lo_r <= lo_fix_s;
            end
            DONE: begin
               cnt_r <= CNT_Z;
            end
            default: begin
               cnt_r <= CNT_Z;
            end
         endcase
      end
   end

   assign busy     = busy_r;
   assign done     = done_r;
   assign div_zero = div_zero_r;
   assign hi       = hi_r;
   assign lo       = lo_r;

endmodule

// File: tb/tb_mult_div_seq.sv
// Table-driven bench for mult_div_seq plus hand-written multi-cycle corner cases.
// Honours MULTDIV_DIVZERO_TRAP_EN to select the expected divide-by-zero behaviour.
module tb_mult_div_seq;

   localparam int W = 32;
   localparam int LAT = W + 2;

   logic          clk;
   logic          reset;
   logic          start;
   logic          op;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          busy;
   logic          done;
   logic          div_zero;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;

   int pass_cnt;
   int total_cnt;

   typedef struct {
      string        name;
      logic         op;
      logic [31:0]  a;
      logic [31:0]  b;
      logic [31:0]  exp_hi;
      logic [31:0]  exp_lo;
   } vec_t;

   vec_t vecs[10];

   mult_div_seq #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi       (hi),
      .lo       (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Caller is 1 time unit after a rising edge; this cycle becomes cycle 0.
   task automatic run_op(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                         output int lat);
      int cyc;
      start = 1'b1;
      op    = op_i;
      a     = a_i;
      b     = b_i;
      tick();
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
      op    = ~op_i;
      cyc   = 1;
      while (!done && cyc < 100) begin
         tick();
         cyc++;
      end
      lat = (cyc < 100) ? cyc : -1;
   endtask

   initial begin
      int lat;
      int n_done;
      int first_done;
      logic [31:0] last_hi, last_lo;

      pass_cnt  = 0;
      total_cnt = 0;
      start = 1'b0;
      op    = 1'b0;
      a     = 32'h0;
      b     = 32'h0;

      vecs[0] = '{"mul_3_m5",    1'b0, 32'h0000_0003, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
      vecs[1] = '{"mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      vecs[2] = '{"div_m7_2",    1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3] = '{"div_min_m1",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      vecs[4] = '{"mul_shift",   1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
      vecs[5] = '{"div_100_m7",  1'b1, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2};
      vecs[6] = '{"div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E};
      vecs[7] = '{"mul_m1_m1",   1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
      vecs[8] = '{"mul_max_max", 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
      vecs[9] = '{"div_5_7",     1'b1, 32'h0000_0005, 32'h0000_0007, 32'h0000_0005, 32'h0000_0000};

      // Reset and reset values.
      reset = 1'b1;
      tick();
      tick();
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_dz",   {63'd0, div_zero}, 64'd0);
      chk("rst_hi",   {32'd0, hi}, 64'd0);
      chk("rst_lo",   {32'd0, lo}, 64'd0);
      reset = 1'b0;
      tick();

      // Back-to-back table: each start lands in the first cycle busy is low.
      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
         chk({vecs[i].name, "_lat"},  lat, LAT);
         chk({vecs[i].name, "_hi"},   {32'd0, hi}, {32'd0, vecs[i].exp_hi});
         chk({vecs[i].name, "_lo"},   {32'd0, lo}, {32'd0, vecs[i].exp_lo});
         chk({vecs[i].name, "_dz"},   {63'd0, div_zero}, 64'd0);
         chk({vecs[i].name, "_busyd"}, {63'd0, busy}, 64'd1);
         tick();
         chk({vecs[i].name, "_done1"}, {63'd0, done}, 64'd0);
         chk({vecs[i].name, "_idle"},  {63'd0, busy}, 64'd0);
      end
      last_hi = vecs[9].exp_hi;
      last_lo = vecs[9].exp_lo;

      // Results hold while idle.
      for (int i = 0; i < 5; i++) tick();
      chk("hold_hi", {32'd0, hi}, {32'd0, last_hi});
      chk("hold_lo", {32'd0, lo}, {32'd0, last_lo});

      // Divide by zero.
`ifdef MULTDIV_DIVZERO_TRAP_EN
      run_op(1'b1, 32'h0000_0007, 32'h0000_0000, lat);
      chk("dz_lat", lat, 1);
      chk("dz_flag", {63'd0, div_zero}, 64'd1);
      chk("dz_hi", {32'd0, hi}, {32'd0, last_hi});
      chk("dz_lo", {32'd0, lo}, {32'd0, last_lo});
      tick();
      chk("dz_idle", {63'd0, busy}, 64'd0);
      run_op(1'b0, 32'h0000_0002, 32'h0000_0003, lat);
      chk("dz_clr", {63'd0, div_zero}, 64'd0);
      chk("dz_after_lo", {32'd0, lo}, 64'd6);
      tick();
`else
      run_op(1'b1, 32'h0000_0007, 32'h0000_0000, lat);
      chk("dz_lat", lat, LAT);
      chk("dz_flag", {63'd0, div_zero}, 64'd0);
      chk("dz_hi", {32'd0, hi}, 64'd7);
      chk("dz_lo", {32'd0, lo}, 64'hFFFF_FFFF);
      tick();
      run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0000, lat);
      chk("dzn_hi", {32'd0, hi}, 64'hFFFF_FFF9);
      chk("dzn_lo", {32'd0, lo}, 64'h0000_0001);
      tick();
`endif

      // start pulsed in cycle 10 of a running MULT is ignored.
      start = 1'b1; op = 1'b0; a = 32'h0000_0003; b = 32'hFFFF_FFFB;
      tick();
      start = 1'b0;
      n_done = 0;
      first_done = 0;
      for (int c = 1; c <= 45; c++) begin
         if (c == 10) begin
            start = 1'b1; op = 1'b1; a = 32'h0000_0064; b = 32'h0000_0003;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            n_done++;
            if (first_done == 0) first_done = c;
         end
         tick();
      end
      chk("ign_ndone", n_done, 1);
      chk("ign_cycle", first_done, LAT);
      chk("ign_hi", {32'd0, hi}, 64'hFFFF_FFFF);
      chk("ign_lo", {32'd0, lo}, 64'hFFFF_FFF1);
      chk("ign_idle", {63'd0, busy}, 64'd0);

      // Reset in cycle 20 of a DIV aborts it.
      start = 1'b1; op = 1'b1; a = 32'h0000_0064; b = 32'h0000_0007;
      tick();
      start = 1'b0;
      for (int c = 1; c < 20; c++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_busy", {63'd0, busy}, 64'd0);
      chk("abort_done", {63'd0, done}, 64'd0);
      chk("abort_hi", {32'd0, hi}, 64'd0);
      chk("abort_lo", {32'd0, lo}, 64'd0);
      n_done = 0;
      for (int c = 0; c < 40; c++) begin
         if (done || busy) n_done++;
         tick();
      end
      chk("abort_quiet", n_done, 0);

      // Reset and start together: start is dropped.
      run_op(1'b0, 32'h0000_0005, 32'h0000_0006, lat);
      chk("pre_lo", {32'd0, lo}, 64'd30);
      tick();
      reset = 1'b1; start = 1'b1; op = 1'b0; a = 32'h0000_0009; b = 32'h0000_0009;
      tick();
      reset = 1'b0; start = 1'b0;
      chk("rs_busy", {63'd0, busy}, 64'd0);
      chk("rs_lo", {32'd0, lo}, 64'd0);
      n_done = 0;
      for (int c = 0; c < 40; c++) begin
         if (done || busy) n_done++;
         tick();
      end
      chk("rs_quiet", n_done, 0);
      chk("rs_lo_hold", {32'd0, lo}, 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
